// File: rtl/fmul_pkg.sv
// fmul_pkg: shared definitions for the FMul sharing block and its arbiter.
//   FP_W      operand/result width
//   FMUL_LAT  fixed FMul pipeline latency (single source for MUL_LAT)
//   TAG_ID_W  tag ID width, sized for the largest supported requester count (8)
//   fmul_tag_t {v, id} entry of the result-tag pipeline
//   arb_mode_e arbitration mode select
package fmul_pkg;

    localparam int FP_W     = 32;
    localparam int FMUL_LAT = 4;
    localparam int TAG_ID_W = 3;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } fmul_tag_t;

endpackage

// File: rtl/fmul_arbiter_if.sv
// fmul_arbiter_if: requester-side request and response bundle.
//   req_valid/req_ready  per-requester handshake (N_REQ bits)
//   req_a/req_b          packed operands, slice i = [32*i+31:32*i]
//   resp_valid/resp_id/resp_data  one-cycle result pulse with requester ID
// Modports: master = clients, slave = fmul_arbiter.
interface fmul_arbiter_if
    import fmul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [FP_W*N_REQ-1:0] req_a;
    logic [FP_W*N_REQ-1:0] req_b;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [FP_W-1:0]       resp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational single-grant arbiter.
//   req        request vector (N bits)
//   ptr        round-robin search start index
//   mode       ARB_RR: search from ptr with wrap; ARB_FIXED: index 0 highest
//   grant      one-hot grant (zero when no request)
//   grant_idx  encoded granted index
//   grant_valid  any grant issued
module rr_arbiter
    import fmul_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] start_idx;
    int unsigned      cand;

    assign start_idx = (mode == ARB_RR) ? ptr : '0;

    // First requester found walking up from start_idx, wrapping modulo N.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (int'(start_idx) + k) % N;
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares one pipelined FMul among N_REQ requesters.
//   clk, rst    clock; asynchronous active-high reset
//   rr_mode     1 = round-robin, 0 = fixed priority
//   bus         fmul_arbiter_if.slave: requests in, grants and tagged results out
//   mul_in1/2   registered operands to FMul
//   mul_out     FMul result, MUL_LAT cycles after mul_in1/2 change
//   busy        any operation in flight
module fmul_arbiter
    import fmul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = FMUL_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rr_mode,
    fmul_arbiter_if.slave   bus,
    output logic [FP_W-1:0] mul_in1,
    output logic [FP_W-1:0] mul_in2,
    input  logic [FP_W-1:0] mul_out,
    output logic            busy
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [FP_W-1:0] mul_in1_q, mul_in1_d;
    logic [FP_W-1:0] mul_in2_q, mul_in2_d;
    fmul_tag_t       tag_q [MUL_LAT+1];
    fmul_tag_t       tag_d [MUL_LAT+1];

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_valid;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req         (bus.req_valid),
        .ptr         (ptr_q),
        .mode        (arb_mode_e'(rr_mode)),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign bus.req_ready = grant;

    always_comb begin
        ptr_d     = ptr_q;
        mul_in1_d = mul_in1_q;
        mul_in2_d = mul_in2_q;
        tag_d[0]  = '0;
        for (int unsigned i = 1; i <= MUL_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (grant_valid) begin
            ptr_d     = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            mul_in1_d = bus.req_a[FP_W*grant_idx +: FP_W];
            mul_in2_d = bus.req_b[FP_W*grant_idx +: FP_W];
            tag_d[0]  = '{v: 1'b1, id: TAG_ID_W'(grant_idx)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            mul_in1_q <= '0;
            mul_in2_q <= '0;
            tag_q     <= '{default: '0};
        end else begin
            ptr_q     <= ptr_d;
            mul_in1_q <= mul_in1_d;
            mul_in2_q <= mul_in2_d;
            tag_q     <= tag_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i <= MUL_LAT; i++) begin
            busy = busy | tag_q[i].v;
        end
    end

    assign mul_in1        = mul_in1_q;
    assign mul_in2        = mul_in2_q;
    assign bus.resp_valid = tag_q[MUL_LAT].v;
    assign bus.resp_id    = tag_q[MUL_LAT].id[ID_W-1:0];
    assign bus.resp_data  = mul_out;

    // The shared tag type is sized for 8 requesters; narrower IDs leave the
    // upper bits at zero.
    if (ID_W < TAG_ID_W) begin : g_id_pad
        logic unused_id_hi;
        assign unused_id_hi = ^tag_q[MUL_LAT].id[TAG_ID_W-1:ID_W];
    end

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: scoreboard bench for fmul_arbiter with a behavioural FMul stand-in.
module tb_fmul_arbiter;
    import fmul_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = FMUL_LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic        rr_mode;
    logic [31:0] mul_in1, mul_in2, mul_out;
    logic        busy;

    always #5 clk = ~clk;

    fmul_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();

    fmul_arbiter #(
        .N_REQ   (N),
        .ID_W    (IDW),
        .MUL_LAT (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rr_mode (rr_mode),
        .bus     (bus),
        .mul_in1 (mul_in1),
        .mul_in2 (mul_in2),
        .mul_out (mul_out),
        .busy    (busy)
    );

    // Stand-in FMul: the arbiter never interprets operands, so a deterministic
    // function that is exact for x*1.0 is enough to track data through.
    function automatic logic [31:0] fake_fmul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000) return b;
        if (b == 32'h3F80_0000) return a;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fake_fmul(mul_in1, mul_in2);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_out = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          issue;
        int          due;
    } exp_t;

    exp_t        exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          ptr_m    = 0;
    logic [31:0] held_a   = '0;
    logic [31:0] held_b   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, want);
        end
    endtask

    // One cycle of stimulus; the reference model predicts the grant and the
    // eventual response, which goes to the scoreboard.
    task automatic step(input logic [N-1:0] v, input logic mode,
                        input logic [32*N-1:0] a, input logic [32*N-1:0] b);
        int          g;
        int          start;
        logic [N-1:0] want_ready;
        logic [31:0] ga, gb;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        rr_mode       = mode;
        #1;
        g     = -1;
        start = mode ? ptr_m : 0;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(start + k) % N]) g = (start + k) % N;
        end
        want_ready = '0;
        if (g >= 0) want_ready[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(want_ready));
        chk("mul_in1", 64'(mul_in1), 64'(held_a));
        chk("mul_in2", 64'(mul_in2), 64'(held_b));
        if (g >= 0) begin
            ga = a[32*g +: 32];
            gb = b[32*g +: 32];
            exp_q.push_back('{id: g, data: fake_fmul(ga, gb), issue: cyc, due: cyc + LAT + 1});
            held_a = ga;
            held_b = gb;
            ptr_m  = (g + 1) % N;
        end
    endtask

    function automatic logic [32*N-1:0] pat(input logic [31:0] base);
        logic [32*N-1:0] r;
        for (int i = 0; i < N; i++) r[32*i +: 32] = base + 32'(i) * 32'h0101_0101;
        return r;
    endfunction

    function automatic logic [32*N-1:0] one(input int i, input logic [31:0] val);
        logic [32*N-1:0] r;
        r = pat(32'hDEAD_0000);
        r[32*i +: 32] = val;
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, '0, '0);
    endtask

    task automatic apply_reset_model();
        exp_q.delete();
        ptr_m  = 0;
        held_a = '0;
        held_b = '0;
    endtask

    // Monitor: compares DUT responses and busy against the scoreboard.
    initial begin
        forever begin
            logic busy_want;
            logic due_now;
            @(negedge clk);
            #2;
            busy_want = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].issue < cyc) busy_want = 1'b1;
            chk("busy", 64'(busy), 64'(busy_want));
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL resp_missing: id %0d due cycle %0d never seen", exp_q[0].id, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("resp_valid", 64'(bus.resp_valid), 64'(due_now));
            if (due_now) begin
                if (bus.resp_valid) begin
                    chk("resp_id", 64'(bus.resp_id), 64'(exp_q[0].id));
                    chk("resp_data", 64'(bus.resp_data), 64'(exp_q[0].data));
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int bound;
        rst           = 1'b1;
        rr_mode       = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #1;
        chk("reset_mul_in1", 64'(mul_in1), 64'h0);
        chk("reset_mul_in2", 64'(mul_in2), 64'h0);
        chk("reset_resp_valid", 64'(bus.resp_valid), 64'h0);
        chk("reset_resp_id", 64'(bus.resp_id), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        idle(2);
        @(negedge clk);
        rst = 1'b0;

        // Denormal operand passes through; requester 0.
        step(4'b0001, 1'b1, one(0, 32'h0000_0001), one(0, 32'h3F80_0000));
        idle(7);

        // Single op from requester 2: 1.0 * 2.0.
        step(4'b0100, 1'b1, one(2, 32'h3F80_0000), one(2, 32'h4000_0000));
        idle(7);

        // Three back-to-back ops, then asynchronous reset while in flight.
        step(4'b0001, 1'b1, pat(32'h1111_0000), pat(32'h2222_0000));
        step(4'b0010, 1'b1, pat(32'h3333_0000), pat(32'h4444_0000));
        step(4'b0100, 1'b1, pat(32'h5555_0000), pat(32'h6666_0000));
        idle(1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        apply_reset_model();
        #1;
        chk("async_rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        chk("async_rst_mul_in1", 64'(mul_in1), 64'h0);
        chk("async_rst_resp_id", 64'(bus.resp_id), 64'h0);
        idle(3);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // All requesters valid in round-robin from pointer 0.
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, pat(32'hA000_0000 + 32'(i)), pat(32'hB000_0000));
        idle(7);

        // Fixed priority: 1 beats 3, then 3 once 1 drops.
        for (int i = 0; i < 4; i++) step(4'b1010, 1'b0, pat(32'hC000_0000 + 32'(i)), pat(32'h3F80_0000));
        step(4'b1000, 1'b0, pat(32'hC100_0000), pat(32'h3F80_0000));
        idle(7);

        // Transfer, three idle cycles, transfer.
        step(4'b0001, 1'b1, pat(32'hE000_0000), pat(32'hE100_0000));
        idle(3);
        step(4'b0010, 1'b1, pat(32'hE200_0000), pat(32'hE300_0000));
        idle(7);

        // Random traffic with mixed modes and special operand values.
        for (int i = 0; i < 300; i++) begin
            logic [32*N-1:0] ra, rb;
            for (int j = 0; j < N; j++) begin
                case ($urandom_range(0, 5))
                    0:       ra[32*j +: 32] = 32'h7F80_0000;
                    1:       ra[32*j +: 32] = 32'h7FC0_0001;
                    2:       ra[32*j +: 32] = 32'h0000_0000;
                    default: ra[32*j +: 32] = $urandom;
                endcase
                rb[32*j +: 32] = ($urandom_range(0, 3) == 0) ? 32'h3F80_0000 : $urandom;
            end
            step(N'($urandom), 1'($urandom), ra, rb);
        end

        bound = 0;
        while (exp_q.size() > 0 && bound < 20) begin
            idle(1);
            bound++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Shares one pipelined single-precision multiplier (FMul, 4-cycle fixed latency, no stall) among N_REQ requesters.
- Arbitrates requests with valid/ready handshakes and registers the granted operands into the multiplier inputs.
- Carries each operation's requester ID down a tag pipeline aligned with the multiplier, and returns each result with its ID as a one-cycle pulse.
- Sits between the shading/compute clients and the single FMul instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must equal clog2(N_REQ), minimum 1.
- MUL_LAT, 4, cycles from multiplier operand change to the corresponding `out`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rr_mode  in  1  1 = round-robin, 0 = fixed priority (index 0 highest); sampled every cycle.
- req_valid  in  N_REQ  per-requester operation valid.
- req_a  in  32*N_REQ  operand A; slice i = [32*i+31:32*i].
- req_b  in  32*N_REQ  operand B, same slicing.
- req_ready  out  N_REQ  one-hot (or zero) grant; a transfer happens when req_valid[i] & req_ready[i].
- mul_in1  out  32  to FMul in1, registered.
- mul_in2  out  32  to FMul in2, registered.
- mul_out  in  32  from FMul out.
- resp_valid  out  1  one-cycle pulse, result available.
- resp_id  out  ID_W  requester index of the result.
- resp_data  out  32  result; equals mul_out during the resp_valid cycle.
- busy  out  1  1 while any operation is in flight.

Behaviour:
Reset:
- mul_in1 = mul_in2 = 0, all tag-pipe valid bits = 0, rr pointer = 0, resp_valid = 0, resp_id = 0, busy = 0.
- Asserting rst mid-operation drops every in-flight result; no resp_valid is produced for those operations.

Grant (combinational, at most one grant per cycle):
- Round-robin: search starts at index ptr and wraps modulo N_REQ; the first requester with valid set is granted.
- Fixed priority: the lowest asserted index is granted.
- No requester valid: req_ready is all zero.
- req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer update on a transfer to requester g: ptr <= (g+1) mod N_REQ. This applies in both modes, so switching rr_mode takes effect cleanly.
- Pointer with no transfer: unchanged.

Issue:
- On a transfer, the granted req_a/req_b are captured into mul_in1/mul_in2. Stage-0 tag {v=1, id=g} is written.
- With no transfer, mul_in1/mul_in2 hold their previous value and stage-0 tag v = 0.
- The multiplier runs every cycle, so garbage results are simply untagged.

Tag pipeline:
- MUL_LAT+1 entries of {v, id}, shifting every cycle.
- The final entry drives resp_valid/resp_id. resp_data is connected directly to mul_out.
- Timing: a transfer at edge c yields resp_valid in cycle c+MUL_LAT+1 (5 cycles with defaults).
- Back-to-back transfers on consecutive edges produce consecutive resp_valid cycles with matching IDs, in issue order.
- Throughput is 1 op/cycle; there is no response backpressure, and consumers must accept results.

busy:
- OR of all tag valid bits.
- Deasserts in the first cycle after the last resp_valid, provided no new transfer has occurred.

Other rules:
- Simultaneous valid from all requesters in rr_mode: each is served once per N_REQ cycles, never starved.
- Operand values are not interpreted (zeros, denormals, Inf/NaN pass through).

Decomposition:
- Shared package fmul_pkg holds:
  - FP_W=32.
  - FMUL_LAT=4, the single source for MUL_LAT.
  - typedef fmul_tag_t {logic v; logic [ID_W-1:0] id}.
- Sub-module rr_arbiter (N inputs, ptr, mode → one-hot grant plus encoded index). It is reused by the planned FAdd sharing block.
- The tag shift register stays inline.

Test Plan:
1. Reset, then requester 2 sends a=0x3F800000, b=0x40000000 at edge c → req_ready=4'b0100 in cycle c; resp_valid=1, resp_id=2, resp_data=0x40000000 exactly in cycle c+5; busy falls in c+6.
2. All four requesters hold valid, rr_mode=1, 8 cycles → grant order 0,1,2,3,0,1,2,3; resp_id sequence identical, 5 cycles delayed, on 8 consecutive resp_valid cycles.
3. rr_mode=0, requesters 1 and 3 valid for 4 cycles → only requester 1 granted; req_ready[3]=0 throughout. Requester 1 then drops valid → requester 3 granted the next cycle.
4. Issue 3 ops on consecutive edges, assert rst 2 cycles after the last one → outputs return to reset values immediately (asynchronously); no resp_valid for any of the 3; busy=0.
5. a=0x00000001 (denormal), b=0x3F800000 from requester 0 → resp_data=0x00000001, resp_id=0.
6. Idle gaps: a transfer, 3 idle cycles, a transfer → exactly two resp_valid pulses, 4 cycles apart, with mul_in1 held during the gap.
